mod11_stream_acc: RTL and testbench
===================================

// Module: mod11_stream_acc
// PURPOSE
//  Streaming mod-11 remainder of multi-word operands, MS word first. Each 64-bit
//  word is reduced by the existing combinational div_64_11 residue stage, which this
//  block feeds and whose 4-bit R it consumes. Per-word residues fold Horner-style:
//  acc' = (5*acc + r) mod 11, since 2^64 mod 11 = 5. Result is emitted per message.
// PARAMETERS
//  CNT_W   16  width of the word counter (saturating)
// PORTS
//  clk        in   1      rising-edge clock, sole clock
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      input word valid
//  in_ready   out  1      block accepts a word this cycle
//  in_data    in   64     operand word, bit 63 = MSB (maps to div_64_11 X[64])
//  in_first   in   1      word is the first (most significant) of a message
//  in_last    in   1      word is the last of a message (first&last = 1-word msg)
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      consumer accepts result
//  out_rem    out  4      message value mod 11, range 0..10
//  out_words  out  CNT_W  words in message, saturates at 2^CNT_W-1
//  out_err    out  1      protocol error seen in this message
// BEHAVIOUR
//  - Reset: in_ready=1 in the cycle after reset, out_valid=0, out_rem=0, out_words=0,
//    out_err=0; stage A empty, acc=0, no message open. Reset mid-message discards
//    all partial state and any pending result.
//  - Stage A: on in_valid&in_ready, register word plus first/last; a_valid=1.
//    div_64_11 sees the registered word; r = its R.
//  - Stage B (fold): when a_valid and advancing: if a_first, acc=r and cnt=1;
//    else acc=(5*acc+r) mod 11 and cnt=sat(cnt+1). If a_last, load out_rem with the
//    new acc, out_words with the new cnt, out_err with the new err; set out_valid;
//    close the message.
//  - Stall: a_adv = a_valid & !(a_last & out_valid & !out_ready);
//    in_ready = !a_valid | a_adv. Non-last words always advance.
//  - Latency: last word accepted at edge t -> out_valid=1 after edge t+1.
//    Throughput 1 word/cycle with no back-pressure.
//  - Output handshake: out_valid falls on out_valid&out_ready unless a new result
//    loads on the same edge; a new load then wins, keeping out_valid=1.
//  - Protocol errors set err, which is reported with the result and cleared when
//    the next message opens:
//    * word without in_first while no message is open: treated as first, err=1;
//    * in_first while a message is open: restart acc/cnt, err=1.
//  - Arithmetic: 5*acc+r <= 60; reduce by mod-11 lookup. r outside 0..10 cannot
//    occur; assert in simulation.
// STRUCTURE
//  - Package mod11_pkg holds:
//    * MOD_DIV=11, WORD_RES=5 (2^64 mod 11), RES_W=4
//    * function fold_mod11(acc,r)
//  - Sub-modules:
//    * instantiates div_64_11 (unchanged) for the per-word residue;
//    * one new sub-module, mod11_fold: combinational (5*acc+r) mod 11.
//  - Control: the open/closed message flag is the only FSM, 2 states IDLE/OPEN.
// TESTING
//  1. 1-word msg 64'd100, first=last=1 -> out_rem=1, out_words=1, err=0, 2 cycles later.
//  2. 1-word msg 64'hFFFF_FFFF_FFFF_FFFF -> out_rem=4.
//  3. 2 words {1,0} -> out_rem=5; {1,3} -> out_rem=8; 3 words {1,0,0} -> out_rem=3,
//     out_words=3.
//  4. Back-pressure: hold out_ready=0 after msg A, stream msg B -> in_ready drops
//     only while B's last is in stage A; A stays stable; B is delivered after A
//     is accepted.
//  5. Errors:
//     * word with in_first=0 after reset -> result with err=1;
//     * in_first mid-message -> result reflects only the restarted words, err=1.
//  6. rst mid-message, then 1-word msg 64'd22 -> out_rem=0, out_words=1, err=0;
//     no stale result emitted.

Source files
------------

// File: rtl/mod11_pkg.sv
// Shared constants, message-state encoding and the mod-11 fold helper
// for the streaming mod-11 accumulator.
package mod11_pkg;

    localparam int unsigned MOD_DIV  = 11;
    localparam int unsigned WORD_RES = 5;   // 2^64 mod 11
    localparam int unsigned RES_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } acc_state_t;

    // (WORD_RES*acc + r) mod 11; with acc, r <= 10 the sum is at most 60,
    // so a five-step compare chain covers every possible quotient.
    function automatic logic [RES_W-1:0] fold_mod11(
        input logic [RES_W-1:0] acc,
        input logic [RES_W-1:0] r
    );
        logic [5:0] s;
        s = 6'(WORD_RES) * {2'b00, acc} + {2'b00, r};
        if (s >= 6'(5 * MOD_DIV))
            s = s - 6'(5 * MOD_DIV);
        else if (s >= 6'(4 * MOD_DIV))
            s = s - 6'(4 * MOD_DIV);
        else if (s >= 6'(3 * MOD_DIV))
            s = s - 6'(3 * MOD_DIV);
        else if (s >= 6'(2 * MOD_DIV))
            s = s - 6'(2 * MOD_DIV);
        else if (s >= 6'(MOD_DIV))
            s = s - 6'(MOD_DIV);
        return s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/div_64_11.sv
// Combinational residue of a 64-bit word modulo 11.
// X[64] is the most significant bit; R is in 0..10.
module div_64_11 (
    input  logic [64:1] X,
    output logic [3:0]  R
);

    logic [3:0] part;
    logic [4:0] t;

    // Bit-serial remainder, MSB first: part = (2*part + bit) mod 11.
    always_comb begin
        part = '0;
        t    = '0;
        for (int unsigned i = 64; i >= 1; i--) begin
            t = {part, X[i]};
            if (t >= 5'd11)
                t = t - 5'd11;
            part = t[3:0];
        end
        R = part;
    end

endmodule

// File: rtl/mod11_fold.sv
// Combinational Horner step: acc_next = (5*acc + r) mod 11.
module mod11_fold
    import mod11_pkg::*;
(
    input  logic [RES_W-1:0] acc,
    input  logic [RES_W-1:0] r,
    output logic [RES_W-1:0] acc_next
);

    // Single fold of the running residue with the new word residue.
    always_comb begin
        acc_next = fold_mod11(acc, r);
    end

endmodule

// File: rtl/mod11_stream_acc.sv
// Streaming mod-11 remainder of multi-word messages, MS word first.
// Stage A registers the word; stage B folds its residue into the running
// accumulator and, on the last word, loads the held result register.
module mod11_stream_acc
    import mod11_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_rem,
    output logic [CNT_W-1:0] out_words,
    output logic             out_err
);

    logic             a_valid;
    logic             a_first;
    logic             a_last;
    logic [63:0]      a_data;
    logic             a_adv;

    logic [RES_W-1:0] r;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] acc_fold;
    logic [RES_W-1:0] acc_new;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_new;
    logic             err;
    logic             err_new;
    logic             start_new;
    logic             proto_err;

    acc_state_t       state;
    acc_state_t       state_next;

    div_64_11 u_div (
        .X (a_data),
        .R (r)
    );

    mod11_fold u_fold (
        .acc      (acc),
        .r        (r),
        .acc_next (acc_fold)
    );

    // Only a last word can stall, and only while a previous result is unread.
    always_comb begin
        a_adv    = a_valid & ~(a_last & out_valid & ~out_ready);
        in_ready = ~a_valid | a_adv;
    end

    // Stage A: capture an accepted word with its framing flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_first <= 1'b0;
            a_last  <= 1'b0;
            a_data  <= '0;
        end else if (in_ready) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_data  <= in_data;
                a_first <= in_first;
                a_last  <= in_last;
            end
        end
    end

    // Message state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next message state plus whether this word opens a message and is malformed.
    always_comb begin
        state_next = state;
        start_new  = 1'b0;
        proto_err  = 1'b0;
        case (state)
            IDLE: begin
                start_new = 1'b1;
                proto_err = ~a_first;
                if (a_adv)
                    state_next = a_last ? IDLE : OPEN;
            end
            OPEN: begin
                start_new = a_first;
                proto_err = a_first;
                if (a_adv && a_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // New accumulator, saturating word count and sticky error for the stage-A word.
    always_comb begin
        acc_new = start_new ? r : acc_fold;
        if (start_new)
            cnt_new = CNT_W'(1);
        else if (&cnt)
            cnt_new = cnt;
        else
            cnt_new = cnt + CNT_W'(1);
        err_new = start_new ? proto_err : err;
    end

    // Stage B: commit the fold when the stage-A word advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else if (a_adv) begin
            acc <= acc_new;
            cnt <= cnt_new;
            err <= err_new;
        end
    end

    // Result register: a new load wins over a same-cycle consumer handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rem   <= '0;
            out_words <= '0;
            out_err   <= 1'b0;
        end else if (a_adv && a_last) begin
            out_valid <= 1'b1;
            out_rem   <= acc_new;
            out_words <= cnt_new;
            out_err   <= err_new;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // The residue stage must never hand back a value outside 0..10.
    always_ff @(posedge clk) begin
        if (!rst && a_valid)
            assert (r < RES_W'(MOD_DIV));
    end

endmodule

// File: tb/tb_mod11_stream_acc.sv
// Self-checking bench for mod11_stream_acc: directed literal cases plus
// randomized framing/back-pressure checked against a big-integer model.
module tb_mod11_stream_acc;

    localparam int unsigned CW  = 2;
    localparam int unsigned SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_first;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_rem;
    logic [CW-1:0] out_words;
    logic          out_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int rem;
        int words;
        int err;
    } res_t;

    res_t         q[$];
    bit           m_open = 1'b0;
    logic [127:0] m_acc  = '0;
    int           m_cnt  = 0;
    bit           m_err  = 1'b0;
    bit           rnd_done;

    always #5 clk = ~clk;

    mod11_stream_acc #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rem   (out_rem),
        .out_words (out_words),
        .out_err   (out_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Model and output compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_open = 1'b0;
            m_acc  = '0;
            m_cnt  = 0;
            m_err  = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stale_result: out_valid=1 rem=%0d with no result expected", out_rem);
                end else begin
                    chk("model_rem",   64'(out_rem),   64'(q[0].rem));
                    chk("model_words", 64'(out_words), 64'(q[0].words));
                    chk("model_err",   64'(out_err),   64'(q[0].err));
                    if (out_ready)
                        void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                if (!m_open || in_first) begin
                    m_err = m_open ? 1'b1 : !in_first;
                    m_acc = '0;
                    m_cnt = 0;
                end
                m_acc = ((m_acc << 64) + {64'd0, in_data}) % 128'd11;
                m_cnt++;
                if (in_last) begin
                    q.push_back('{int'(m_acc[31:0]), (m_cnt > int'(SAT)) ? int'(SAT) : m_cnt, int'(m_err)});
                    m_open = 1'b0;
                end else begin
                    m_open = 1'b1;
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Present a word (at posedge+1) and return just after the edge that accepts it.
    task automatic put_word(input logic [63:0] d, input logic f, input logic l, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, want 1", waits);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input string nm, input int rem, input int words, input int err);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_rem"},   64'(out_rem),   64'(rem));
        chk({nm, "_words"}, 64'(out_words), 64'(words));
        chk({nm, "_err"},   64'(out_err),   64'(err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want $finish");
        $fatal(1);
    end

    initial begin
        int w;
        logic [63:0] d;
        bit f;
        int len;
        int n;

        rst       = 1'b1;
        out_ready = 1'b1;
        in_data   = '0;
        rnd_done  = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_rem",   64'(out_rem),   64'd0);
        chk("rst_out_words", 64'(out_words), 64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);

        // Single word 100, latency check.
        sync();
        put_word(64'd100, 1'b1, 1'b1, w);
        idle();
        @(negedge clk);
        chk("lat_early_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("w100_rem",   64'(out_rem),   64'd1);
        chk("w100_words", 64'(out_words), 64'd1);
        chk("w100_err",   64'(out_err),   64'd0);

        sync();
        put_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, w);
        idle();
        wait_res("ones", 4, 1, 0);

        sync();
        put_word(64'd1, 1'b1, 1'b0, w);
        put_word(64'd0, 1'b0, 1'b1, w);
        idle();
        wait_res("m10", 5, 2, 0);

        sync();
        put_word(64'd1, 1'b1, 1'b0, w);
        put_word(64'd3, 1'b0, 1'b1, w);
        idle();
        wait_res("m13", 8, 2, 0);

        sync();
        put_word(64'd1, 1'b1, 1'b0, w);
        put_word(64'd0, 1'b0, 1'b0, w);
        put_word(64'd0, 1'b0, 1'b1, w);
        idle();
        wait_res("m100", 3, 3, 0);

        // Five words 1..5 -> 7 mod 11, count saturates at 3.
        sync();
        for (int unsigned i = 1; i <= 5; i++)
            put_word(64'(i), i == 1, i == 5, w);
        idle();
        wait_res("sat", 7, 3, 0);

        // Back-pressure: A held unread while B streams in.
        sync();
        out_ready = 1'b0;
        put_word(64'd100, 1'b1, 1'b1, w);
        idle();
        wait_res("bpA", 1, 1, 0);
        sync();
        put_word(64'd7, 1'b1, 1'b0, w);
        chk("bp_w0_wait", 64'(w), 64'd0);
        put_word(64'd9, 1'b0, 1'b0, w);
        chk("bp_w1_wait", 64'(w), 64'd0);
        put_word(64'd13, 1'b0, 1'b1, w);
        chk("bp_w2_wait", 64'(w), 64'd0);
        idle();
        @(negedge clk);
        chk("bp_stall_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_rem",    64'(out_rem),  64'd1);
        repeat (3) @(negedge clk);
        chk("bp_stall_ready2", 64'(in_ready),  64'd0);
        chk("bp_hold_valid",   64'(out_valid), 64'd1);
        chk("bp_hold_rem2",    64'(out_rem),   64'd1);
        sync();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_A_rem", 64'(out_rem), 64'd1);
        @(negedge clk);
        chk("bp_B_valid", 64'(out_valid), 64'd1);
        chk("bp_B_rem",   64'(out_rem),   64'd2);
        chk("bp_B_words", 64'(out_words), 64'd3);
        chk("bp_ready",   64'(in_ready),  64'd1);

        // Missing first after reset.
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        put_word(64'd100, 1'b0, 1'b1, w);
        idle();
        wait_res("nofirst", 1, 1, 1);

        // Restart mid-message: only {1,0} counts.
        sync();
        put_word(64'd5, 1'b1, 1'b0, w);
        put_word(64'd7, 1'b0, 1'b0, w);
        put_word(64'd1, 1'b1, 1'b0, w);
        put_word(64'd0, 1'b0, 1'b1, w);
        idle();
        wait_res("restart", 5, 2, 1);

        // Reset mid-message discards the partial message.
        sync();
        put_word(64'd3, 1'b1, 1'b0, w);
        put_word(64'd4, 1'b0, 1'b0, w);
        idle();
        rst = 1'b1;
        sync();
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        sync();
        put_word(64'd22, 1'b1, 1'b1, w);
        idle();
        wait_res("w22", 0, 1, 0);

        // Randomized messages, framing errors and consumer back-pressure.
        sync();
        fork
            begin
                for (int m = 0; m < 60; m++) begin
                    len = int'($urandom_range(1, 6));
                    for (int k = 0; k < len; k++) begin
                        case ($urandom_range(0, 3))
                            0:       d = 64'hFFFF_FFFF_FFFF_FFFF;
                            1:       d = 64'($urandom_range(0, 30));
                            default: d = {$urandom, $urandom};
                        endcase
                        f = (k == 0);
                        if ($urandom_range(0, 11) == 0)
                            f = !f;
                        put_word(d, f, k == len - 1, w);
                        if ($urandom_range(0, 3) == 0) begin
                            idle();
                            repeat ($urandom_range(1, 3)) sync();
                        end
                    end
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    sync();
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results still expected after %0d cycles, want 0", q.size(), n);
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
